// File: rtl/dbc_pkg.sv
// Shared types for the debounce event scheduler: channel FSM states and event polarity codes.
package dbc_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    W1   = 2'd1,
    ONE  = 2'd2,
    W0   = 2'd3
  } dbc_state_t;

  localparam logic EV_PRESS   = 1'b0;
  localparam logic EV_RELEASE = 1'b1;

endpackage

// File: rtl/dbc_ev_if.sv
// Button event port: valid/ready handshake carrying channel id, press/release flag and overflow pulse.
interface dbc_ev_if #(
  parameter int N_BTN = 4
);
  localparam int IDW = $clog2(N_BTN);

  logic           ev_valid;
  logic           ev_ready;
  logic [IDW-1:0] ev_id;
  logic           ev_rel;
  logic           ev_ovf;

  modport master (output ev_valid, output ev_id, output ev_rel, output ev_ovf, input ev_ready);
  modport slave  (input ev_valid, input ev_id, input ev_rel, input ev_ovf, output ev_ready);
endinterface

// File: rtl/dbc_channel.sv
// One early-detection debounce channel: db follows the first edge at once, then ignores the pin
// for WAIT_TICKS ticks; rise/fall flag the db edges taken on the coming clock edge.
module dbc_channel
  import dbc_pkg::*;
#(
  parameter int WAIT_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam logic [1:0] WLAST = 2'(WAIT_TICKS - 1);

  dbc_state_t state, state_nxt;
  logic [1:0] wcnt, wcnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ZERO;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    rise      = 1'b0;
    fall      = 1'b0;
    case (state)
      ZERO: if (btn) begin
        state_nxt = W1;
        wcnt_nxt  = '0;
        rise      = 1'b1;
      end
      W1: if (tick) begin
        if (wcnt == WLAST) begin
          state_nxt = btn ? ONE : ZERO;
          fall      = !btn;
        end else begin
          wcnt_nxt = wcnt + 2'd1;
        end
      end
      ONE: if (!btn) begin
        state_nxt = W0;
        wcnt_nxt  = '0;
        fall      = 1'b1;
      end
      W0: if (tick) begin
        if (wcnt == WLAST) begin
          state_nxt = btn ? ONE : ZERO;
          rise      = btn;
        end else begin
          wcnt_nxt = wcnt + 2'd1;
        end
      end
      default: state_nxt = ZERO;
    endcase
  end

  // ZERO is Mealy on btn so a press shows up in the same cycle it is first seen.
  assign db = !reset && (((state == ZERO) && btn) || (state == W1) || (state == ONE));

endmodule

// File: rtl/dbc_event_scheduler.sv
// N_BTN debounce channels on one shared tick, press/release edges queued as pending flags and
// served round-robin on a valid/ready port; DBC_RELEASE_EVT_EN enables release events.
module dbc_event_scheduler
  import dbc_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int M          = 1_000_000,
  parameter int WAIT_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] db,
  dbc_ev_if.master         ev
);

  localparam int             IDW       = $clog2(N_BTN);
  localparam int             CW        = $clog2(M);
  localparam logic [CW-1:0]  TICK_LAST = CW'(M - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N_BTN - 1);

  logic [CW-1:0]    tick_cnt;
  logic             tick;
  logic [N_BTN-1:0] rise, fall;
  logic [N_BTN-1:0] press_pend, rel_pend, req, win_oh, clr_press, clr_rel, press_nxt;
  logic [IDW-1:0]   rr_ptr, win, ptr_nxt, cand;
  logic             found, win_press, load, take, ovf_press, ovf_rel;
  logic             ev_valid_q, ev_rel_q, ev_ovf_q;
  logic [IDW-1:0]   ev_id_q;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    dbc_channel #(.WAIT_TICKS(WAIT_TICKS)) u_ch (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[g]),
      .tick (tick),
      .db   (db[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  assign req = press_pend | rel_pend;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % N_BTN);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_press = press_pend[win];
  assign load      = !ev_valid_q || ev.ev_ready;
  assign take      = load && found;
  assign win_oh    = take ? (N_BTN'(1) << win) : '0;
  assign clr_press = win_press ? win_oh : '0;
  assign clr_rel   = win_press ? '0 : win_oh;
  assign ptr_nxt   = (win == ID_LAST) ? '0 : win + 1'b1;

  // A set on the same edge as a clear wins; a set onto a surviving flag is an overflow.
  assign press_nxt = rise | (press_pend & ~clr_press);
  assign ovf_press = |(rise & press_pend & ~clr_press);

`ifdef DBC_RELEASE_EVT_EN
  logic [N_BTN-1:0] rel_nxt;
  assign rel_nxt = fall | (rel_pend & ~clr_rel);
  assign ovf_rel = |(fall & rel_pend & ~clr_rel);

  always_ff @(posedge clk) begin
    if (reset) rel_pend <= '0;
    else       rel_pend <= rel_nxt;
  end

  assign ev.ev_rel = ev_rel_q;
`else
  logic unused_rel;
  assign rel_pend   = '0;
  assign ovf_rel    = 1'b0;
  assign unused_rel = ^{fall, clr_rel, ev_rel_q};
  assign ev.ev_rel  = EV_PRESS;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      press_pend <= '0;
      rr_ptr     <= '0;
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      ev_rel_q   <= EV_PRESS;
      ev_ovf_q   <= 1'b0;
    end else begin
      press_pend <= press_nxt;
      ev_ovf_q   <= ovf_press || ovf_rel;
      if (load) begin
        ev_valid_q <= found;
        if (found) begin
          ev_id_q  <= win;
          ev_rel_q <= win_press ? EV_PRESS : EV_RELEASE;
          rr_ptr   <= ptr_nxt;
        end
      end
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_id    = ev_id_q;
  assign ev.ev_ovf   = ev_ovf_q;

endmodule

// File: doc/dbc_event_scheduler.md
# dbc_event_scheduler

Multi-button debounce controller. It schedules N_BTN early-detection debounce channels from one shared 10 ms tick prescaler. Debounced press and release edges are collected into per-channel pending flags, and a round-robin arbiter serialises them onto one valid/ready event port. It sits between the board push-buttons and any consumer that wants discrete button events rather than levels.

## Interface
- N_BTN, 4: number of button channels, 2..16
- M, 1_000_000: clocks per tick (100 MHz / 100 Hz = 10 ms); M ≥ 2
- WAIT_TICKS, 3: ticks per wait window, 1..4
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- btn  in  N_BTN  raw button levels, already synchronised upstream
- db  out  N_BTN  debounced levels
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event
- ev_id  out  $clog2(N_BTN)  channel of the event
- ev_rel  out  1  0 = press, 1 = release
- ev_ovf  out  1  one-cycle pulse: an edge was coalesced into an already-set pending flag

## Operation
- Prescaler: tick_cnt counts 0..M-1 and wraps. tick is high for one cycle when tick_cnt == M-1. It is free-running and shared by all channels.
- Channel FSM states: ZERO, W1, ONE, W0. Each channel has a 2-bit wait counter wcnt.
  - ZERO: btn → W1, wcnt = 0.
  - W1: on tick, wcnt++. On the tick where wcnt == WAIT_TICKS-1: btn → ONE, else → ZERO.
  - ONE: !btn → W0, wcnt = 0.
  - W0: same as W1; the final tick goes to btn ? ONE : ZERO.
  - Without a tick, W1 and W0 hold.
- db (Mealy): (ZERO & btn) | W1 | ONE. db is forced to 0 while reset is high.
- Edges:
  - db rising (ZERO→W1, W0→ONE) sets press_pend[i].
  - db falling (ONE→W0, W1→ZERO) sets rel_pend[i], only when the macro is on.
- Coalescing: an edge arriving while the same flag is already set and not being cleared that edge leaves the flag at 1 and pulses ev_ovf. If a set and a clear hit the same flag on the same edge, set wins.
- Arbiter:
  - The output register loads when ev_valid == 0 or (ev_valid & ev_ready).
  - Winner: the first channel with any pending flag, searching upward from rr_ptr with wrap.
  - If a channel has both flags set, press goes first.
  - Loading clears the winner's flag and sets rr_ptr = winner+1, wrapping at N_BTN.
  - If nothing is pending, ev_valid drops after acceptance.
- Handshake: ev_id and ev_rel stay stable while ev_valid & !ev_ready. ev_valid never drops without acceptance except on reset.

## Timing
- Reset values:
  - All channels ZERO, wcnt 0, tick_cnt 0.
  - All pending flags 0, rr_ptr 0.
  - ev_valid 0, ev_id 0, ev_rel 0, ev_ovf 0, db 0.
- A reset mid-wait or mid-handshake discards everything on the next edge.
- Press latency:
  - db rises combinationally in the cycle btn is first seen high in ZERO.
  - The FSM transition and the pending set happen on edge E.
  - ev_valid is high after edge E+1 if the output slot is free.
- Throughput: one event per cycle while ev_ready is held high.
- Wait-window length is (WAIT_TICKS-1)·M+1 to WAIT_TICKS·M clocks, because tick phase is arbitrary.
- wcnt arithmetic is 2-bit, with no wrap past WAIT_TICKS-1.

## Configuration
- DBC_RELEASE_EVT_EN:
  - Defined: release edges generate events with ev_rel = 1.
  - Undefined: rel_pend is not built, ev_rel is tied to 0, and only presses are reported. db behaviour is identical either way.

## Structure
- Package dbc_pkg holds:
  - the dbc_state_t enum (ZERO, W1, ONE, W0);
  - localparam EV_PRESS = 1'b0 and EV_RELEASE = 1'b1.
- Sub-module dbc_channel: one FSM plus wcnt. Inputs are clk, reset, btn, tick. Outputs are db, rise, fall. It is instantiated N_BTN times with generate.
- The prescaler and arbiter live in the top level. The prescaler is inline because it needs a synchronous reset.

## Test plan
All scenarios use M=4, WAIT_TICKS=3, N_BTN=4, macro on unless stated.
- Reset with btn=4'hF held for 3 cycles → db=0 and ev_valid=0 throughout. After reset is released, db=4'hF in the same cycle, and ev_valid=1, ev_id=0, ev_rel=0 one edge after the transition. With ev_ready=1, ids 0,1,2,3 follow on consecutive cycles.
- btn[0] high for 2 cycles, then low (bounce) → db[0]=1 during W1, then 0 after the third tick. Events: press id 0, then release id 0. With the macro off: press only, ev_rel always 0.
- btn[1] clean press held 40 cycles → db[1]=1 continuously from the first cycle. Exactly one event: id 1, ev_rel=0.
- btn[1] and btn[2] rise in the same cycle with ev_ready=0 for 10 cycles → ev_valid=1, ev_id=1, stable for all 10 cycles. Then ev_ready=1 → id 2 on the next cycle, then ev_valid=0.
- With ev_ready=0, ch3 produces three debounced presses → the first sits in the output register, the second is pending, and the third pulses ev_ovf for one cycle. After ev_ready=1, exactly two press events with id 3 are delivered, plus the release events.
- Assert reset while ch0 is in W1 and ev_valid=1 → after the next edge, ev_valid=0, all pending flags are clear, and db[0]=btn[0] via the ZERO Mealy term.
